sam_mem_ctrl: RTL and testbench

Memory-side bus slave for the Very Half SAM accumulator CPU. Sits directly downstream of the CPU control unit on its multiplexed 8-bit address/data bus: latches the address on ALE, serves zero-wait reads and writes of a 256-byte RAM, and owns a boot loader. The boot loader fills RAM from a byte-stream handshake while holding the CPU in reset.

---
 rtl/sam_mem_pkg.sv | 28 ++
 rtl/sam_mem_ctrl_if.sv | 30 +++
 rtl/sam_ram.sv | 22 ++
 rtl/sam_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_sam_mem_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sam_mem_pkg.sv
// Shared types and constants for the SAM memory controller.
package sam_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_ADDR  = 2'd1,
        CYC_READ  = 2'd2,
        CYC_WRITE = 2'd3
    } cyc_e;

    // ALE wins over En/Rw: an address cycle never touches memory.
    function automatic cyc_e decode_cyc(input logic ale, input logic en, input logic rw);
        if (ale) return CYC_ADDR;
        if (!en) return CYC_IDLE;
        if (rw)  return CYC_READ;
        return CYC_WRITE;
    endfunction

endpackage

// File: rtl/sam_mem_ctrl_if.sv
// CPU bus and boot-loader handshake between the SAM CPU side and the memory controller.
interface sam_mem_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              ALE;
    logic              En;
    logic              Rw;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              cpu_hold;
    logic              ld_done;
    logic              err_wp;

    modport master (
        output ALE, En, Rw, bus_in, ld_start, ld_len, ld_valid, ld_data,
        input  bus_out, bus_oe, ld_ready, cpu_hold, ld_done, err_wp
    );

    modport slave (
        input  ALE, En, Rw, bus_in, ld_start, ld_len, ld_valid, ld_data,
        output bus_out, bus_oe, ld_ready, cpu_hold, ld_done, err_wp
    );
endinterface

// File: rtl/sam_ram.sv
// Single-port-write, asynchronous-read RAM; contents are never reset.
module sam_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sam_mem_ctrl.sv
// Memory-side bus slave for the SAM CPU with a boot loader that fills RAM while holding the CPU.
// Optional write protection above WP_BASE is enabled by defining SAM_WRITE_PROTECT_EN.
//
// state  | meaning
// S_RUN  | serve CPU address/read/write cycles
// S_LOAD | CPU held, accept one loader byte per cycle into RAM
// S_DONE | one-cycle ld_done pulse, CPU still held
module sam_mem_ctrl
    import sam_mem_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] WP_BASE = 8'hF0
) (
    input logic           clk,
    input logic           rst,
    sam_mem_ctrl_if.slave bif
);
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    cyc_e              cyc;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              wp_base_hit;
    logic              bus_oe, ld_ready, cpu_hold, ld_done, err_wp;

`ifdef SAM_WRITE_PROTECT_EN
    assign wp_base_hit = (addr_q >= WP_BASE);
`else
    logic unused_wp_base;
    assign unused_wp_base = ^WP_BASE;
    assign wp_base_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
            addr_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        we       = 1'b0;
        waddr    = addr_q;
        wdata    = bif.bus_in;
        bus_oe   = 1'b0;
        ld_ready = 1'b0;
        cpu_hold = 1'b0;
        ld_done  = 1'b0;
        err_wp   = 1'b0;
        cyc      = decode_cyc(bif.ALE, bif.En, bif.Rw);

        unique case (state_q)
            S_RUN: begin
                case (cyc)
                    CYC_ADDR:  addr_d = ADDR_W'(bif.bus_in);
                    CYC_READ:  bus_oe = 1'b1;
                    CYC_WRITE: begin
                        we     = !wp_base_hit;
                        err_wp = wp_base_hit;
                    end
                    default: ;
                endcase
                if (bif.ld_start) begin
                    cnt_d   = (bif.ld_len == '0) ? FULL_CNT : {1'b0, bif.ld_len};
                    ptr_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cpu_hold = 1'b1;
                ld_ready = 1'b1;
                if (bif.ld_valid) begin
                    we    = 1'b1;
                    waddr = ptr_q;
                    wdata = bif.ld_data;
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{ADDR_W{1'b0}}, 1'b1}) state_d = S_DONE;
                end
            end
            S_DONE: begin
                cpu_hold = 1'b1;
                ld_done  = 1'b1;
                state_d  = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        // Reset is synchronous, so suppress outputs and RAM writes while it is asserted.
        if (!rst) begin
            we       = 1'b0;
            bus_oe   = 1'b0;
            ld_ready = 1'b0;
            cpu_hold = 1'b0;
            ld_done  = 1'b0;
            err_wp   = 1'b0;
        end
    end

    sam_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk    (clk),
        .we_i   (we),
        .waddr_i(waddr),
        .wdata_i(wdata),
        .raddr_i(addr_q),
        .rdata_o(rdata)
    );

    assign bif.bus_out  = bus_oe ? rdata : '0;
    assign bif.bus_oe   = bus_oe;
    assign bif.ld_ready = ld_ready;
    assign bif.cpu_hold = cpu_hold;
    assign bif.ld_done  = ld_done;
    assign bif.err_wp   = err_wp;
endmodule

// File: tb/tb_sam_mem_ctrl.sv
// Directed bench for sam_mem_ctrl: CPU bus vector table plus loader, reset-abort and write-protect sequences.
module tb_sam_mem_ctrl;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef SAM_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    sam_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bif ();

    sam_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .WP_BASE(8'hF0)) dut (
        .clk(clk),
        .rst(rst),
        .bif(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       ale;
        logic       en;
        logic       rw;
        logic [7:0] bin;
        logic       exp_oe;
        logic [7:0] exp_out;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input logic r, input logic a, input logic e,
                                input logic w, input logic [7:0] b, input logic oe,
                                input logic [7:0] o, input logic er);
        vec_t v;
        v.name = nm; v.rst = r; v.ale = a; v.en = e; v.rw = w; v.bin = b;
        v.exp_oe = oe; v.exp_out = o; v.exp_err = er;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bif.ALE = 1'b0; bif.En = 1'b0; bif.Rw = 1'b1; bif.bus_in = 8'h00;
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp, input string nm);
        bif.ALE = 1'b1; bif.En = 1'b0; bif.bus_in = a;
        step();
        bif.ALE = 1'b0; bif.En = 1'b1; bif.Rw = 1'b1; bif.bus_in = 8'h00;
        @(negedge clk);
        chk({nm, "_oe"}, bif.bus_oe, 1'b1);
        chk(nm, bif.bus_out, exp);
        step();
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int cyc;
        logic [7:0] ld_bytes [3];
        ld_bytes[0] = 8'h60; ld_bytes[1] = 8'h05; ld_bytes[2] = 8'h00;

        rst = 1'b0;
        idle_bus();
        bif.ld_start = 1'b0; bif.ld_len = 8'h00; bif.ld_valid = 1'b0; bif.ld_data = 8'h00;

        //   name          rst ale en rw bus_in  oe out    err
        add("rst_idle",    0,  0,  0, 1, 8'h00,  0, 8'h00, 0);
        add("rst_read",    0,  0,  1, 1, 8'h00,  0, 8'h00, 0);
        add("ale_12",      1,  1,  0, 1, 8'h12,  0, 8'h00, 0);
        add("wr_a5",       1,  0,  1, 0, 8'hA5,  0, 8'h00, 0);
        add("rd_a5",       1,  0,  1, 1, 8'h00,  1, 8'hA5, 0);
        add("idle",        1,  0,  0, 1, 8'h00,  0, 8'h00, 0);
        add("ale_13",      1,  1,  0, 0, 8'h13,  0, 8'h00, 0);
        add("wr_3c",       1,  0,  1, 0, 8'h3C,  0, 8'h00, 0);
        add("rd_3c",       1,  0,  1, 1, 8'h00,  1, 8'h3C, 0);
        add("rd_3c_again", 1,  0,  1, 1, 8'h00,  1, 8'h3C, 0);
        add("wr_4d",       1,  0,  1, 0, 8'h4D,  0, 8'h00, 0);
        add("rd_4d",       1,  0,  1, 1, 8'h00,  1, 8'h4D, 0);
        add("ale_rd_12",   1,  1,  1, 1, 8'h12,  0, 8'h00, 0);
        add("rd_a5_back",  1,  0,  1, 1, 8'h00,  1, 8'hA5, 0);
        add("ale_ef",      1,  1,  0, 1, 8'hEF,  0, 8'h00, 0);
        add("wr_ef",       1,  0,  1, 0, 8'h77,  0, 8'h00, 0);
        add("rd_ef",       1,  0,  1, 1, 8'h00,  1, 8'h77, 0);
        add("ale_20",      1,  1,  0, 1, 8'h20,  0, 8'h00, 0);

        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            bif.ALE = vecs[i].ale; bif.En = vecs[i].en; bif.Rw = vecs[i].rw;
            bif.bus_in = vecs[i].bin;
            @(negedge clk);
            chk({vecs[i].name, "_oe"},   bif.bus_oe,   vecs[i].exp_oe);
            chk({vecs[i].name, "_out"},  bif.bus_out,  vecs[i].exp_out);
            chk({vecs[i].name, "_err"},  bif.err_wp,   vecs[i].exp_err);
            chk({vecs[i].name, "_hold"}, bif.cpu_hold, 1'b0);
            chk({vecs[i].name, "_rdy"},  bif.ld_ready, 1'b0);
            step();
        end
        idle_bus();

        // Three-byte load; a CPU write to 0x20 shares the ld_start cycle.
        bif.ld_start = 1'b1; bif.ld_len = 8'd3;
        bif.En = 1'b1; bif.Rw = 1'b0; bif.bus_in = 8'h99;
        @(negedge clk);
        chk("l3_start_hold", bif.cpu_hold, 1'b0);
        chk("l3_start_rdy",  bif.ld_ready, 1'b0);
        step();
        bif.ld_start = 1'b0;
        idle_bus();
        for (int k = 0; k < 3; k++) begin
            bif.ld_valid = 1'b1; bif.ld_data = ld_bytes[k];
            bif.ALE = (k == 1); bif.bus_in = 8'h55;
            @(negedge clk);
            chk($sformatf("l3_hold_%0d", k), bif.cpu_hold, 1'b1);
            chk($sformatf("l3_rdy_%0d", k),  bif.ld_ready, 1'b1);
            chk($sformatf("l3_done_%0d", k), bif.ld_done,  1'b0);
            step();
        end
        bif.ld_valid = 1'b0;
        idle_bus();
        @(negedge clk);
        chk("l3_done_hold", bif.cpu_hold, 1'b1);
        chk("l3_done_rdy",  bif.ld_ready, 1'b0);
        chk("l3_done",      bif.ld_done,  1'b1);
        step();
        bif.En = 1'b1; bif.Rw = 1'b1;
        @(negedge clk);
        chk("l3_after_hold", bif.cpu_hold, 1'b0);
        chk("l3_after_done", bif.ld_done,  1'b0);
        chk("l3_frozen_addr_rd", bif.bus_out, 8'h99);
        step();
        idle_bus();
        cpu_read(8'h00, 8'h60, "l3_mem0");
        cpu_read(8'h01, 8'h05, "l3_mem1");
        cpu_read(8'h02, 8'h00, "l3_mem2");

        // Full 256-byte load with ld_valid on every other cycle.
        bif.ld_start = 1'b1; bif.ld_len = 8'd0;
        step();
        bif.ld_start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 256 && cyc < 600) begin
            bif.ld_valid = (cyc % 2 == 0);
            bif.ld_data  = 8'(idx) ^ 8'hA5;
            @(negedge clk);
            chk("l256_hold", bif.cpu_hold, 1'b1);
            chk("l256_rdy",  bif.ld_ready, 1'b1);
            chk("l256_done", bif.ld_done,  1'b0);
            step();
            if (bif.ld_valid) idx++;
            cyc++;
        end
        chk("l256_bytes_accepted", 9'(idx), 9'd256);
        bif.ld_valid = 1'b0;
        @(negedge clk);
        chk("l256_done_pulse", bif.ld_done, 1'b1);
        step();
        @(negedge clk);
        chk("l256_hold_drop", bif.cpu_hold, 1'b0);
        for (int a = 0; a < 256; a++) begin
            cpu_read(8'(a), 8'(a) ^ 8'hA5, $sformatf("l256_mem_%02h", a));
        end

        // Protected region write.
        bif.ALE = 1'b1; bif.bus_in = 8'hF3;
        step();
        bif.ALE = 1'b0; bif.En = 1'b1; bif.Rw = 1'b0; bif.bus_in = 8'h77;
        @(negedge clk);
        chk("wp_err_pulse", bif.err_wp, WP);
        step();
        idle_bus();
        @(negedge clk);
        chk("wp_err_clear", bif.err_wp, 1'b0);
        step();
        cpu_read(8'hF3, WP ? 8'h56 : 8'h77, "wp_mem_f3");

        // Reset in the middle of a five-byte load.
        bif.ld_start = 1'b1; bif.ld_len = 8'd5;
        step();
        bif.ld_start = 1'b0;
        bif.ld_valid = 1'b1; bif.ld_data = 8'hB0;
        step();
        bif.ld_data = 8'hB1;
        step();
        rst = 1'b0; bif.ld_data = 8'hB2;
        @(negedge clk);
        chk("abort_hold", bif.cpu_hold, 1'b0);
        chk("abort_rdy",  bif.ld_ready, 1'b0);
        chk("abort_done", bif.ld_done,  1'b0);
        step();
        rst = 1'b1; bif.ld_valid = 1'b0;
        @(negedge clk);
        chk("post_abort_hold", bif.cpu_hold, 1'b0);
        chk("post_abort_done", bif.ld_done,  1'b0);
        chk("post_abort_rdy",  bif.ld_ready, 1'b0);
        step();
        cpu_read(8'h00, 8'hB0, "abort_mem0");
        cpu_read(8'h01, 8'hB1, "abort_mem1");
        cpu_read(8'h02, 8'hA7, "abort_mem2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
